// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter in front of one shared bitwise-AND unit. The winning operands are
// ANDed into a single result register, returned with the requester index on a valid/ready channel.
module and_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    input  logic                     resp_ready,
    output logic [CNTW-1:0]          served_cnt
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [IDW-1:0]    ptr_reg;
    logic [IDW-1:0]    resp_id_reg;
    logic [WIDTH-1:0]  resp_data_reg;
    logic [CNTW-1:0]   served_cnt_reg;

    logic [WIDTH-1:0]  and_res [NREQ];
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;
    logic              can_accept;
    logic [IDW-1:0]    ptr_next;
    int                rot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_and
            assign and_res[gi] = req_a[gi*WIDTH +: WIDTH] & req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Nothing is granted in the reset cycle, so requests presented then are neither taken nor counted.
    assign can_accept = !rst && ((state_reg == EMPTY) || resp_ready);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        rot       = 0;
        if (can_accept) begin
            for (int k = 0; k < NREQ; k++) begin
                rot = int'(ptr_reg) + k;
                if (rot >= NREQ) begin
                    rot = rot - NREQ;
                end
                if (!grant_any && req_valid[rot]) begin
                    grant_any       = 1'b1;
                    grant_idx       = IDW'(rot);
                    grant[rot]      = 1'b1;
                end
            end
        end
    end

    assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= EMPTY;
            ptr_reg        <= '0;
            resp_id_reg    <= '0;
            resp_data_reg  <= '0;
            served_cnt_reg <= '0;
        end else if (grant_any) begin
            state_reg      <= FULL;
            resp_data_reg  <= and_res[grant_idx];
            resp_id_reg    <= grant_idx;
            ptr_reg        <= ptr_next;
            served_cnt_reg <= served_cnt_reg + CNTW'(1);
        end else if ((state_reg == FULL) && resp_ready) begin
            // Drain only: data and id keep their last values.
            state_reg      <= EMPTY;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = (state_reg == FULL);
    assign resp_data  = resp_data_reg;
    assign resp_id    = resp_id_reg;
    assign served_cnt = served_cnt_reg;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter: stimulus pushes expected responses into a queue,
// a negedge monitor pops them on every response handshake.
module tb_and_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic        resp_ready;
    logic [15:0] served_cnt;

    logic [3:0]  w_req_ready;
    logic        w_resp_valid;
    logic [7:0]  w_resp_data;
    logic [1:0]  w_resp_id;
    logic [3:0]  w_served_cnt;

    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    and_unit_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_id(resp_id), .resp_ready(resp_ready), .served_cnt(served_cnt)
    );

    and_unit_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(4)) dut_wrap (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(w_req_ready), .resp_valid(w_resp_valid), .resp_data(w_resp_data),
        .resp_id(w_resp_id), .resp_ready(resp_ready), .served_cnt(w_served_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_id", 32'(resp_id), 32'(e[9:8]));
                check("resp_data", 32'(resp_data), 32'(e[7:0]));
                $display("resp id=%0d data=%02h", resp_id, resp_data);
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy,
                        input string nm);
        logic [1:0] g;
        req_valid  = v;
        resp_ready = rr;
        #3;
        check(nm, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
            g = 2'd0;
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) g = 2'(i);
            exp_q.push_back({g, req_a[g*8 +: 8] & req_b[g*8 +: 8]});
        end
        $display("step %s valid=%b resp_ready=%b grant=%b", nm, v, rr, req_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] v);
        rst        = 1'b1;
        req_valid  = v;
        resp_ready = 1'b0;
        #3;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_served", 32'(served_cnt), 32'd0);
        $display("reset valid=%b", v);
    endtask

    initial begin
        // a = {a3,a2,a1,a0}, b likewise; results 0:81 1:30 2:36 3:0A
        req_a      = {8'hAA, 8'h77, 8'hF0, 8'hFF};
        req_b      = {8'h0F, 8'h3E, 8'h3C, 8'h81};
        rst        = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset(4'b1111);
        check("reset_resp_data", 32'(resp_data), 32'd0);
        check("reset_resp_id", 32'(resp_id), 32'd0);

        // Single request
        step(4'b0010, 1'b1, 4'b0010, "single_grant");
        check("single_valid", 32'(resp_valid), 32'd1);
        check("single_data", 32'(resp_data), 32'h30);
        check("single_id", 32'(resp_id), 32'd1);
        check("single_served", 32'(served_cnt), 32'd1);
        step(4'b0000, 1'b1, 4'b0000, "single_drain");
        check("drain_valid", 32'(resp_valid), 32'd0);
        check("drain_hold_data", 32'(resp_data), 32'h30);
        check("drain_hold_id", 32'(resp_id), 32'd1);

        // Round-robin fairness from ptr=0
        do_reset(4'b0000);
        for (int k = 0; k < 8; k++) step(4'b1111, 1'b1, 4'b0001 << (k % 4), "rr_grant");
        step(4'b0000, 1'b1, 4'b0000, "rr_drain");
        check("rr_served", 32'(served_cnt), 32'd8);

        // Backpressure
        step(4'b1111, 1'b1, 4'b0001, "bp_fill");
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b0, 4'b0000, "bp_stall");
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_data", 32'(resp_data), 32'h81);
            check("bp_id", 32'(resp_id), 32'd0);
        end
        step(4'b1111, 1'b1, 4'b0010, "bp_refill");
        check("bp_refill_id", 32'(resp_id), 32'd1);
        step(4'b0000, 1'b1, 4'b0000, "bp_drain");
        check("bp_served", 32'(served_cnt), 32'd10);

        // Skip idle requesters: bring ptr to 1, then 1001 -> 3 then 0
        step(4'b0001, 1'b1, 4'b0001, "skip_setup");
        step(4'b0000, 1'b1, 4'b0000, "skip_setup_drain");
        step(4'b1001, 1'b1, 4'b1000, "skip_grant3");
        step(4'b1001, 1'b1, 4'b0001, "skip_grant0");
        step(4'b0000, 1'b1, 4'b0000, "skip_drain");
        check("skip_served", 32'(served_cnt), 32'd13);

        // Reset mid-operation
        step(4'b0100, 1'b1, 4'b0100, "mid_fill");
        check("mid_valid_before", 32'(resp_valid), 32'd1);
        do_reset(4'b0100);
        check("mid_wrap_served", 32'(w_served_cnt), 32'd0);
        step(4'b0100, 1'b1, 4'b0100, "mid_first_grant");

        // Counter wrap: 16 more accepts, 17 since reset
        for (int k = 0; k < 16; k++) step(4'b1111, 1'b1, 4'b0001 << ((3 + k) % 4), "wrap_grant");
        step(4'b0000, 1'b1, 4'b0000, "wrap_drain");
        check("wrap_served_cntw4", 32'(w_served_cnt), 32'd1);
        check("wrap_served_cntw16", 32'(served_cnt), 32'd17);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
